// File: rtl/msp430_decode_sequencer_if.sv
// Fetch-side word stream and execute-side decoded record for the MSP430 decode sequencer.
// valid/ready: a transfer happens on a rising edge where both are high; the sender holds its payload stable while valid && !ready.
interface msp430_decode_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic [15:0]       word_in;
  logic              word_valid;
  logic              word_ready;
  logic              dec_valid;
  logic              dec_ready;
  logic [15:0]       fs;
  logic [3:0]        src_a;
  logic [3:0]        dst_a;
  logic [1:0]        as;
  logic              ad;
  logic              bw;
  logic              one_op;
  logic              jump;
  logic [ADDR_W-1:0] branch_offset;
  logic [ADDR_W-1:0] src_ext;
  logic [ADDR_W-1:0] dst_ext;
  logic              src_ext_valid;
  logic              dst_ext_valid;
  logic              prefix_valid;
  logic              illegal;

  modport master (
    output word_in, word_valid, dec_ready,
    input  word_ready, dec_valid, fs, src_a, dst_a, as, ad, bw, one_op, jump,
    input  branch_offset, src_ext, dst_ext, src_ext_valid, dst_ext_valid, prefix_valid, illegal
  );

  modport slave (
    input  word_in, word_valid, dec_ready,
    output word_ready, dec_valid, fs, src_a, dst_a, as, ad, bw, one_op, jump,
    output branch_offset, src_ext, dst_ext, src_ext_valid, dst_ext_valid, prefix_valid, illegal
  );
endinterface

// File: rtl/msp430_decode_sequencer.sv
// Collects opcode, optional MSP430X prefix and extension words from fetch, then presents
// one registered decoded record to execute. Unsupported encodings become MOV R3,R3 with illegal set.
module msp430_decode_sequencer #(
  parameter int ADDR_W     = 16,
  parameter bit EXT_ENABLE = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  msp430_decode_sequencer_if.slave bus,
  output logic [2:0]               state_o
);
  typedef enum logic [2:0] {OPC, PFX_OPC, SRC_EXT, DST_EXT, OUT} state_e;

  typedef struct packed {
    logic [15:0]       fs;
    logic [3:0]        src_a;
    logic [3:0]        dst_a;
    logic [1:0]        as;
    logic              ad;
    logic              bw;
    logic              one_op;
    logic              jump;
    logic [ADDR_W-1:0] branch_offset;
    logic [ADDR_W-1:0] src_ext;
    logic [ADDR_W-1:0] dst_ext;
    logic              src_ext_valid;
    logic              dst_ext_valid;
    logic              prefix_valid;
    logic              illegal;
  } rec_t;

  state_e      state_q, state_d;
  rec_t        rec_q, rec_d, op_rec;
  logic [3:0]  snib_q, snib_d, dnib_q, dnib_d;
  logic        dst_pend_q, dst_pend_d;
  logic        op_is_pfx, op_src, op_dst, op_legal;
  logic        word_ready, accept, consume, in_pfx, use_nib;
  logic [15:0] w;

  function automatic logic src_rule(input logic [1:0] mode, input logic [3:0] reg_a);
    return (mode == 2'd1 && reg_a != 4'd3) || (mode == 2'd3 && reg_a == 4'd0);
  endfunction

  function automatic logic [ADDR_W-1:0] ext_val(input logic [3:0] nib, input logic [15:0] x,
                                                input logic wide);
    logic [19:0] v;
    v = wide ? {nib, x} : {4'h0, x};
    return ADDR_W'(v);
  endfunction

  assign w       = bus.word_in;
  assign in_pfx  = (state_q == PFX_OPC);
  // Prefix nibbles only widen operands when the address path is 20 bits.
  assign use_nib = rec_q.prefix_valid && (ADDR_W == 20);

  always_comb begin
    op_rec    = '0;
    op_is_pfx = 1'b0;
    op_src    = 1'b0;
    op_dst    = 1'b0;
    op_legal  = 1'b0;
    case (w[15:12])
      4'h0: op_legal = 1'b0;
      4'h1: begin
        if (w[11]) begin
          op_is_pfx = EXT_ENABLE;
        end else if (!w[10] && w == 16'h1300) begin
          op_legal     = 1'b1;
          op_rec.fs    = 16'h1300;
          op_rec.src_a = 4'd1;
          op_rec.as    = 2'd3;
          op_rec.one_op = 1'b1;
        end else if (!w[10] && w[9:7] != 3'd7) begin
          op_legal      = 1'b1;
          op_rec.fs     = {w[15:6], 6'b0};
          op_rec.src_a  = w[3:0];
          op_rec.dst_a  = w[3:0];
          op_rec.as     = w[5:4];
          op_rec.bw     = w[6];
          op_rec.one_op = 1'b1;
          op_src        = src_rule(w[5:4], w[3:0]);
        end
      end
      4'h2, 4'h3: begin
        if (!in_pfx) begin
          op_legal             = 1'b1;
          op_rec.fs            = {w[15:10], 10'b0};
          op_rec.jump          = 1'b1;
          op_rec.branch_offset = ADDR_W'({{9{w[9]}}, w[9:0], 1'b0});
        end
      end
      default: begin
        op_legal     = 1'b1;
        op_rec.fs    = {w[15:12], 5'b0, w[6], 6'b0};
        op_rec.src_a = w[11:8];
        op_rec.dst_a = w[3:0];
        {op_rec.ad, op_rec.bw, op_rec.as} = w[7:4];
        op_src       = src_rule(w[5:4], w[11:8]);
        op_dst       = w[7];
      end
    endcase
    if (op_legal) begin
      op_rec.prefix_valid = in_pfx;
    end else begin
      op_rec         = '0;
      op_rec.fs      = 16'h4000;
      op_rec.src_a   = 4'd3;
      op_rec.dst_a   = 4'd3;
      op_rec.illegal = 1'b1;
      op_src         = 1'b0;
      op_dst         = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    rec_d      = rec_q;
    snib_d     = snib_q;
    dnib_d     = dnib_q;
    dst_pend_d = dst_pend_q;
    word_ready = (state_q != OUT) || bus.dec_ready;
    accept     = bus.word_valid && word_ready;
    consume    = (state_q == OUT) && bus.dec_ready;
    if (consume) begin
      state_d = OPC;
      snib_d  = 4'h0;
      dnib_d  = 4'h0;
    end
    case (state_q)
      OPC, PFX_OPC, OUT: begin
        if (accept) begin
          if (op_is_pfx) begin
            state_d = PFX_OPC;
            snib_d  = w[10:7];
            dnib_d  = w[3:0];
          end else begin
            rec_d      = op_rec;
            dst_pend_d = op_dst;
            state_d    = op_src ? SRC_EXT : (op_dst ? DST_EXT : OUT);
          end
        end
      end
      SRC_EXT: begin
        if (accept) begin
          rec_d.src_ext       = ext_val(snib_q, w, use_nib);
          rec_d.src_ext_valid = 1'b1;
          state_d             = dst_pend_q ? DST_EXT : OUT;
        end
      end
      DST_EXT: begin
        if (accept) begin
          rec_d.dst_ext       = ext_val(dnib_q, w, use_nib);
          rec_d.dst_ext_valid = 1'b1;
          state_d             = OUT;
        end
      end
      default: state_d = OPC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= OPC;
      rec_q      <= '0;
      snib_q     <= 4'h0;
      dnib_q     <= 4'h0;
      dst_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rec_q      <= rec_d;
      snib_q     <= snib_d;
      dnib_q     <= dnib_d;
      dst_pend_q <= dst_pend_d;
    end
  end

  assign state_o           = state_q;
  assign bus.word_ready    = word_ready;
  assign bus.dec_valid     = (state_q == OUT);
  assign bus.fs            = rec_q.fs;
  assign bus.src_a         = rec_q.src_a;
  assign bus.dst_a         = rec_q.dst_a;
  assign bus.as            = rec_q.as;
  assign bus.ad            = rec_q.ad;
  assign bus.bw            = rec_q.bw;
  assign bus.one_op        = rec_q.one_op;
  assign bus.jump          = rec_q.jump;
  assign bus.branch_offset = rec_q.branch_offset;
  assign bus.src_ext       = rec_q.src_ext;
  assign bus.dst_ext       = rec_q.dst_ext;
  assign bus.src_ext_valid = rec_q.src_ext_valid;
  assign bus.dst_ext_valid = rec_q.dst_ext_valid;
  assign bus.prefix_valid  = rec_q.prefix_valid;
  assign bus.illegal       = rec_q.illegal;
endmodule

// File: tb/tb_msp430_decode_sequencer.sv
// Two decoders (16-bit plain, 20-bit with MSP430X prefixes) fed a shared word stream under random
// handshakes; records are checked against an array-walking decode model.
module tb_msp430_decode_sequencer;
  localparam int REC_W = 94;

  typedef struct packed {
    logic [15:0] fs;
    logic [3:0]  src_a;
    logic [3:0]  dst_a;
    logic [1:0]  as;
    logic        ad, bw, one_op, jump;
    logic [19:0] bo, se, de;
    logic        sev, dev, pv, ill;
  } rec_t;

  logic clk, rst;
  logic [2:0] st16, st20;
  logic [REC_W-1:0] exp16_q[$];
  logic [REC_W-1:0] exp20_q[$];
  logic [REC_W-1:0] act16, act20, held16, held20;
  logic [15:0] words[$];
  logic [15:0] one[$];
  bit hold16, hold20;
  int total = 0;
  int bad   = 0;
  int p16, p20, cyc;

  msp430_decode_sequencer_if #(.ADDR_W(16)) b16 ();
  msp430_decode_sequencer_if #(.ADDR_W(20)) b20 ();

  msp430_decode_sequencer #(.ADDR_W(16), .EXT_ENABLE(1'b0)) dut16 (
    .clk(clk), .rst(rst), .bus(b16), .state_o(st16));
  msp430_decode_sequencer #(.ADDR_W(20), .EXT_ENABLE(1'b1)) dut20 (
    .clk(clk), .rst(rst), .bus(b20), .state_o(st20));

  assign act16 = {b16.fs, b16.src_a, b16.dst_a, b16.as, b16.ad, b16.bw, b16.one_op, b16.jump,
                  4'h0, b16.branch_offset, 4'h0, b16.src_ext, 4'h0, b16.dst_ext,
                  b16.src_ext_valid, b16.dst_ext_valid, b16.prefix_valid, b16.illegal};
  assign act20 = {b20.fs, b20.src_a, b20.dst_a, b20.as, b20.ad, b20.bw, b20.one_op, b20.jump,
                  b20.branch_offset, b20.src_ext, b20.dst_ext,
                  b20.src_ext_valid, b20.dst_ext_valid, b20.prefix_valid, b20.illegal};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_rec(input string name, input logic [REC_W-1:0] act, input logic [REC_W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s act=%0d req=%0d", name, act, req);
    end
  endtask

  // Reference decode: walks the word array, pulling extension words ahead of the opcode pointer.
  function automatic void model_push(input bit is20, input logic [15:0] w[$]);
    int i;
    bit pfx, ns, nd, ok;
    logic [3:0] sn, dn;
    logic [15:0] op, e;
    logic [19:0] t;
    rec_t r;
    i = 0; pfx = 0; sn = 0; dn = 0;
    while (i < w.size()) begin
      op = w[i]; i++;
      r = '0; ns = 0; nd = 0; ok = 1;
      if (op[15:11] == 5'b00011 && is20) begin
        pfx = 1; sn = op[10:7]; dn = op[3:0];
        continue;
      end
      if (op[15:12] >= 4'h4) begin
        r.fs = {op[15:12], 5'b0, op[6], 6'b0};
        r.src_a = op[11:8]; r.dst_a = op[3:0];
        {r.ad, r.bw, r.as} = op[7:4];
        ns = (r.as == 1 && r.src_a != 3) || (r.as == 3 && r.src_a == 0);
        nd = r.ad;
      end else if (op[15:13] == 3'b001 && !pfx) begin
        r.fs = {op[15:10], 10'b0};
        r.jump = 1;
        t = {{9{op[9]}}, op[9:0], 1'b0};
        if (!is20) t[19:16] = 4'h0;
        r.bo = t;
      end else if (op == 16'h1300) begin
        r.fs = 16'h1300; r.src_a = 1; r.dst_a = 0; r.as = 3; r.one_op = 1;
      end else if (op[15:10] == 6'b000100 && op[9:7] != 3'd7) begin
        r.fs = {op[15:6], 6'b0};
        r.src_a = op[3:0]; r.dst_a = op[3:0]; r.as = op[5:4]; r.bw = op[6]; r.one_op = 1;
        ns = (r.as == 1 && r.src_a != 3) || (r.as == 3 && r.src_a == 0);
      end else begin
        ok = 0;
        r.fs = 16'h4000; r.src_a = 3; r.dst_a = 3; r.ill = 1;
      end
      if (ok) r.pv = pfx;
      if (ns) begin
        if (i >= w.size()) break;
        e = w[i]; i++;
        r.se = (is20 && pfx) ? {sn, e} : {4'h0, e};
        r.sev = 1;
      end
      if (nd) begin
        if (i >= w.size()) break;
        e = w[i]; i++;
        r.de = (is20 && pfx) ? {dn, e} : {4'h0, e};
        r.dev = 1;
      end
      if (is20) exp20_q.push_back(REC_W'(r));
      else      exp16_q.push_back(REC_W'(r));
      pfx = 0; sn = 0; dn = 0;
    end
  endfunction

  function automatic logic [15:0] rand_word();
    int c;
    logic [15:0] r;
    c = $urandom_range(0, 15);
    r = 16'($urandom);
    case (c)
      0:       return {4'h0, r[11:0]};
      1, 2:    return {6'b000100, r[9:0]};
      3:       return 16'h1300;
      4:       return {5'b00011, r[10:0]};
      5:       return {6'b000101, r[9:0]};
      6, 7:    return {3'b001, r[12:0]};
      default: return {4'($urandom_range(4, 15)), r[11:0]};
    endcase
  endfunction

  // driver tasks
  task automatic drive_both(input logic v, input logic [15:0] wd, input logic rdy);
    b16.word_valid = v; b16.word_in = wd; b16.dec_ready = rdy;
    b20.word_valid = v; b20.word_in = wd; b20.dec_ready = rdy;
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (rst) hold16 <= 1'b0;
    else if (b16.dec_valid) begin
      if (hold16) check_rec("hold16", act16, held16);
      if (b16.dec_ready) begin
        hold16 <= 1'b0;
        if (exp16_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra16 act=%h req=none", act16);
        end else check_rec("rec16", act16, exp16_q.pop_front());
      end else begin
        check_int("stall_ready16", int'(b16.word_ready), 0);
        hold16 <= 1'b1; held16 <= act16;
      end
    end else hold16 <= 1'b0;
  end

  always @(negedge clk) begin
    if (rst) hold20 <= 1'b0;
    else if (b20.dec_valid) begin
      if (hold20) check_rec("hold20", act20, held20);
      if (b20.dec_ready) begin
        hold20 <= 1'b0;
        if (exp20_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra20 act=%h req=none", act20);
        end else check_rec("rec20", act20, exp20_q.pop_front());
      end else begin
        check_int("stall_ready20", int'(b20.word_ready), 0);
        hold20 <= 1'b1; held20 <= act20;
      end
    end else hold20 <= 1'b0;
  end

  initial begin
    rst = 1'b1;
    drive_both(1'b0, 16'h0000, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_rec("reset_rec16", act16, '0);
    check_rec("reset_rec20", act20, '0);
    check_int("reset_valid16", int'(b16.dec_valid), 0);
    check_int("reset_valid20", int'(b20.dec_valid), 0);
    check_int("reset_ready16", int'(b16.word_ready), 1);
    check_int("reset_ready20", int'(b20.word_ready), 1);
    check_int("reset_state16", int'(st16), 0);
    check_int("reset_state20", int'(st20), 0);
    @(posedge clk); #1 rst = 1'b0;

    words = {16'h4F0E, 16'h40B2, 16'h1234, 16'h0200, 16'h3FFF, 16'h2001, 16'h1300, 16'h0123,
             16'h1980, 16'h4010, 16'hABCD, 16'h1800, 16'h3FFF};
    for (int k = 0; k < 400; k++) words.push_back(rand_word());
    for (int k = 0; k < 3; k++) words.push_back(16'h4303);
    model_push(1'b0, words);
    model_push(1'b1, words);

    // single-word latency: record visible the cycle after acceptance, gone the cycle after that
    drive_both(1'b1, words[0], 1'b1);
    @(negedge clk);
    check_int("lat_ready16", int'(b16.word_ready), 1);
    check_int("lat_ready20", int'(b20.word_ready), 1);
    @(posedge clk); #1 drive_both(1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    check_int("lat_valid16", int'(b16.dec_valid), 1);
    check_int("lat_valid20", int'(b20.dec_valid), 1);
    @(posedge clk); #1;
    @(negedge clk);
    check_int("lat_clear16", int'(b16.dec_valid), 0);
    check_int("lat_clear20", int'(b20.dec_valid), 0);

    p16 = 1; p20 = 1; cyc = 0;
    while ((p16 < words.size() || p20 < words.size() || exp16_q.size() != 0 || exp20_q.size() != 0)
           && cyc < 20000) begin
      @(posedge clk); #1;
      b16.word_valid = (p16 < words.size()) && ($urandom_range(0, 3) != 0);
      b16.word_in    = (p16 < words.size()) ? words[p16] : 16'($urandom);
      b16.dec_ready  = ($urandom_range(0, 3) != 0);
      b20.word_valid = (p20 < words.size()) && ($urandom_range(0, 3) != 0);
      b20.word_in    = (p20 < words.size()) ? words[p20] : 16'($urandom);
      b20.dec_ready  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (b16.word_valid && b16.word_ready) p16++;
      if (b20.word_valid && b20.word_ready) p20++;
      cyc++;
    end
    @(posedge clk); #1 drive_both(1'b0, 16'h0000, 1'b1);
    check_int("stream_words16", p16, words.size());
    check_int("stream_words20", p20, words.size());
    check_int("stream_drain16", exp16_q.size(), 0);
    check_int("stream_drain20", exp20_q.size(), 0);

    // three-cycle stall with a record pending
    one = {16'h4F0E};
    model_push(1'b0, one);
    model_push(1'b1, one);
    drive_both(1'b1, 16'h4F0E, 1'b0);
    @(posedge clk); #1 drive_both(1'b0, 16'h0000, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check_int("stall_valid16", int'(b16.dec_valid), 1);
    check_int("stall_valid20", int'(b20.dec_valid), 1);
    @(posedge clk); #1 drive_both(1'b0, 16'h0000, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_int("stall_drain16", exp16_q.size(), 0);
    check_int("stall_drain20", exp20_q.size(), 0);

    // reset while waiting for a source extension word
    drive_both(1'b1, 16'h40B2, 1'b1);
    @(posedge clk); #1 drive_both(1'b0, 16'h0000, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_rec("midrst_rec16", act16, '0);
    check_rec("midrst_rec20", act20, '0);
    check_int("midrst_valid16", int'(b16.dec_valid), 0);
    check_int("midrst_valid20", int'(b20.dec_valid), 0);
    check_int("midrst_ready20", int'(b20.word_ready), 1);
    check_int("midrst_state20", int'(st20), 0);
    @(posedge clk); #1 rst = 1'b0;
    model_push(1'b0, one);
    model_push(1'b1, one);
    drive_both(1'b1, 16'h4F0E, 1'b1);
    @(posedge clk); #1 drive_both(1'b0, 16'h0000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_int("post_rst_drain16", exp16_q.size(), 0);
    check_int("post_rst_drain20", exp20_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
